// File: rtl/alu6_cmd_queue.sv
// Command FIFO and registered result stage around the external ALU6 unit.
// Optional input OP filtering with error counter: define ALU6_CMD_OPCHECK_EN.
module alu6_cmd_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_a,
  input  logic [3:0]                 in_b,
  input  logic [2:0]                 in_op,
  output logic [3:0]                 alu_a,
  output logic [3:0]                 alu_b,
  output logic [2:0]                 alu_op,
  input  logic [3:0]                 alu_result,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [3:0]                 res_data,
  output logic [2:0]                 res_op,
  output logic [$clog2(DEPTH):0]     level
`ifdef ALU6_CMD_OPCHECK_EN
  ,
  output logic [7:0]                 err_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [10:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [10:0]   head;
  logic          accept;
  logic          op_ok;
  logic          push;
  logic          pop;
  logic          not_empty;

  assign not_empty = (level != '0);
  assign in_ready  = (level != LW'(DEPTH));
  assign accept    = in_valid && in_ready;

`ifdef ALU6_CMD_OPCHECK_EN
  assign op_ok = (in_op <= 3'b100);
`else
  assign op_ok = 1'b1;
`endif

  assign push = accept && op_ok;
  // A push into an empty queue cannot also pop: the head only becomes valid next cycle.
  assign pop  = not_empty && (!res_valid || res_ready);

  assign head   = mem[rd_ptr];
  assign alu_a  = not_empty ? head[10:7] : 4'h0;
  assign alu_b  = not_empty ? head[6:3]  : 4'h0;
  assign alu_op = not_empty ? head[2:0]  : 3'h0;

  // Storage is deliberately left out of reset; level alone qualifies the contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_a, in_b, in_op};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= 4'h0;
      res_op    <= 3'h0;
    end else if (pop) begin
      res_valid <= 1'b1;
      res_data  <= alu_result;
      res_op    <= head[2:0];
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

`ifdef ALU6_CMD_OPCHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'h00;
    end else if (accept && !op_ok && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: doc/alu6_cmd_queue.md
# alu6_cmd_queue

Command buffer and result stage around the 4-bit ALU6 combinational unit. Accepts (A, B, OP) commands over a valid/ready channel and queues them in a small FIFO. Presents the head command to ALU6 and registers the returned result into an output holding register with its own valid/ready handshake. This decouples the command producer and the result consumer from each other and from the ALU.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  command valid
- in_ready  out  1  queue can accept a command
- in_a  in  4  operand A
- in_b  in  4  operand B
- in_op  in  3  operation code
- alu_a  out  4  head operand A to ALU6; 0 when queue empty
- alu_b  out  4  head operand B to ALU6; 0 when queue empty
- alu_op  out  3  head OP to ALU6; 0 when queue empty
- alu_result  in  4  ALU6 combinational result for alu_a/alu_b/alu_op
- res_valid  out  1  result register holds a result
- res_ready  in  1  consumer takes result
- res_data  out  4  registered result
- res_op  out  3  OP that produced res_data
- level  out  clog2(DEPTH)+1  FIFO occupancy

## Operation
- Push: in_valid && in_ready at a clock edge writes {in_a, in_b, in_op} at the write pointer.
- in_ready = (level != DEPTH), purely from state. No push when full, even if a pop happens in the same cycle.
- Head: when level > 0, alu_a/alu_b/alu_op present the entry at the read pointer; otherwise all zero.
- Pop/issue: when level > 0 and (!res_valid || res_ready), the edge pops the head and loads res_data <= alu_result, res_op <= head OP, res_valid <= 1.
- Drain: res_valid && res_ready with no pop clears res_valid. res_data and res_op hold their last values.
- Simultaneous push and pop with level in 1..DEPTH-1: level unchanged, both pointers advance.
- Push into empty queue: level becomes 1. No pop is possible in that cycle, because the head is not yet valid.
- Pointers are clog2(DEPTH) bits and wrap from DEPTH-1 to 0. level is the only full/empty discriminator.
- The block performs no arithmetic. ALU semantics (4-bit wrap on add/sub, OP 101..111 gives 0) belong to ALU6 and pass through unchanged.
- The result is held stable while res_valid && !res_ready.

## Timing
- Reset (asynchronous, immediate): level=0, pointers=0, res_valid=0, res_data=0, res_op=0, so in_ready=1 and alu_* = 0. FIFO storage need not be cleared.
- Reset asserted mid-operation discards all queued commands and any held result. The first accept after rst_n deasserts behaves as if from an empty queue.
- Latency: command accepted at edge k into an empty queue with the result register free. It is issued at edge k+1, and res_valid is high in the cycle after edge k+1.
- Sustained throughput is 1 result/cycle when res_ready is held high.
- The path alu_* -> ALU6 -> alu_result is combinational and must settle within one clock period.

## Configuration
- ALU6_CMD_OPCHECK_EN defined: in_op values 3'b101..3'b111 are rejected at the input. The command is handshaken (in_ready unaffected) but not written, and err_cnt increments, saturating at 8'hFF. This adds output err_cnt (8-bit, reset 0).
- ALU6_CMD_OPCHECK_EN undefined: all OP values are queued, and illegal ones yield res_data=0 via ALU6. There is no err_cnt port.

## Test plan
- Reset: assert rst_n=0 mid-stream with level=3 and res_valid=1 -> level=0, res_valid=0, res_data=0, in_ready=1 immediately, without waiting for a clock edge.
- Single op: push A=4'h7, B=4'h9, OP=000 with res_ready=1 -> res_valid in the cycle after the next edge, res_data=4'h0 (wrap), res_op=000.
- Fill/backpressure: res_ready=0, push 5 commands with DEPTH=4 -> 1 issued to the result register, 4 queued, level=4, in_ready=0. The 6th command is not accepted until res_ready rises.
- Ordering/wrap: push 12 commands of SUB A=i, B=1 while toggling res_ready -> results i-1 mod 16 appear in order. The pointers wrap at least twice.
- Simultaneous push/pop at level=2 with res_ready=1 -> level stays 2 and output order is preserved.
- Illegal OP: push OP=3'b110 -> with ALU6_CMD_OPCHECK_EN, not queued and err_cnt=1; without it, queued and res_data=0, res_op=110.
